ss_job_arbiter: RTL and testbench
=================================

// Module: ss_job_arbiter
// PURPOSE
//  Round-robin scheduler that shares one start/done compute unit among NUM_REQ requesters.
//  It picks one pending request, sends a single start pulse to the unit and waits for done.
//  It then returns a one-cycle ack to the winning requester.
//  Sits between the requesting blocks and the shared unit's start-detect input.
// PARAMETERS
//  NUM_REQ      4    number of requesters, >=2
//  IDX_W        $clog2(NUM_REQ)  grant index width (derived, do not override)
//  TIMEOUT_CYC  255  WAIT-state watchdog limit in cycles; used only with SS_ARB_TIMEOUT_EN
// PORTS
//  i_clk        in   1        clock, rising edge
//  i_rst_n      in   1        asynchronous reset, active-low
//  i_req        in   NUM_REQ  level request per requester; held until its o_ack is sampled
//  i_done       in   1        one-cycle completion pulse from the shared unit
//  o_start      out  1        one-cycle start pulse to the shared unit
//  o_grant      out  NUM_REQ  one-hot current owner; held from ISSUE through ACK
//  o_grant_idx  out  IDX_W    binary index of the current owner
//  o_ack        out  NUM_REQ  one-cycle pulse to the owner when its job ends
//  o_busy       out  1        1 in any state other than IDLE
//  o_err        out  1        qualifies o_ack: job aborted by the watchdog
//  o_abort      out  1        one-cycle abort pulse to the unit on watchdog expiry
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, mask=0; every output is 0. Reset mid-job drops the job silently.
//  FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
//  IDLE: arbitrate over (i_req & ~mask), starting at rr_ptr and searching upward with wrap.
//   If any request wins: latch the winner into o_grant/o_grant_idx and go to ISSUE.
//   mask is cleared each cycle spent in IDLE.
//  ISSUE: o_start=1 for exactly one cycle; rr_ptr <= (winner+1) mod NUM_REQ.
//   If i_done=1 in this cycle, go to ACK; otherwise go to WAIT.
//  WAIT: hold until i_done=1, then go to ACK.
//  ACK: o_ack[winner]=1 for one cycle; mask <= o_grant; go to IDLE.
//   o_grant is cleared on exit from ACK.
//  Latency: i_req rises in IDLE at cycle n -> o_start at n+1. i_done sampled at m -> o_ack at m+1.
//   Back-to-back: next o_start no earlier than m+3.
//  Request handshake: requester drops i_req on the edge where it samples o_ack=1.
//   mask blocks re-grant of the just-acked requester in the first IDLE cycle after ACK.
//  Boundary and ignore rules:
//   - i_done is ignored in IDLE and ACK (stray pulse: no state change).
//   - i_req changes on the owner while ISSUE/WAIT are ignored; the job still completes and is acked.
//   - Several requests in the same cycle: the lowest index at or after rr_ptr wins.
//   - rr_ptr wraps NUM_REQ-1 -> 0.
//   - Only one job is in flight at a time; the unit never sees a second o_start before i_done.
// CONFIGURATION
//  SS_ARB_TIMEOUT_EN defined:
//   - A counter of width $clog2(TIMEOUT_CYC+1) is cleared in ISSUE and incremented in WAIT.
//   - If count==TIMEOUT_CYC with i_done=0: o_abort=1 for one cycle and go to ACK.
//     In that ACK, o_err=1 together with o_ack.
//   - i_done in the same cycle as expiry wins: normal ACK, o_err=0.
//  SS_ARB_TIMEOUT_EN undefined:
//   - No counter is built; o_err and o_abort are tied to 0.
//   - WAIT holds indefinitely.
// TESTING (NUM_REQ=4, TIMEOUT_CYC=8)
//  1. Reset: i_req=4'b1111 during reset -> all outputs 0. After release, o_start at the 2nd edge and o_grant=4'b0001.
//  2. Single job: i_req=4'b0100, i_done 5 cycles after o_start -> o_ack=4'b0100 for 1 cycle, o_grant_idx=2, o_err=0.
//  3. Fairness: i_req held 4'b1111, each requester dropping i_req on its ack -> grant order 0,1,2,3.
//     Then re-raise all four -> order continues 0,1,2,3.
//  4. Mask and stray done: requester 1 alone keeps i_req high one cycle after its ack -> no re-grant in that cycle.
//     Stray i_done in IDLE -> no o_start, no o_ack.
//  5. Timeout (macro on): no i_done for 8 WAIT cycles -> o_abort=1, then o_ack with o_err=1.
//     Macro off: o_busy stays 1 and o_ack never fires.
//  6. Reset asserted in WAIT -> outputs 0 asynchronously. After release, a pending i_req=4'b0010 is granted within 2 cycles.

Source files
------------

// File: rtl/ss_job_arbiter.sv
// ss_job_arbiter: round-robin owner of one shared start/done compute unit.
// Defining SS_ARB_TIMEOUT_EN adds a WAIT-state watchdog that aborts a stuck job.
module ss_job_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int IDX_W       = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_done,
   output logic               o_start,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic [NUM_REQ-1:0] o_ack,
   output logic               o_busy,
   output logic               o_err,
   output logic               o_abort
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;
   localparam int CW = IDX_W + 1;

   if (NUM_REQ < 2) begin : g_bad_num_req
      $error("ss_job_arbiter: NUM_REQ must be at least 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("ss_job_arbiter: TIMEOUT_CYC must be at least 1");
   end

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] mask_q, mask_d;
   logic [NUM_REQ-1:0] req_avail;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   win_idx;
   logic [CW-1:0]      cand;
   logic               win_found;
   logic               expire;

   // The just-acked owner is hidden for one IDLE cycle so a lagging request cannot re-win.
   assign req_avail = i_req & ~mask_q;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr_q} + CW'(i);
         if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
         if (!win_found && req_avail[cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (win_found) state_d = S_ISSUE;
         S_ISSUE: state_d = i_done ? S_ACK : S_WAIT;
         S_WAIT:  if (i_done || expire) state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_start = (state_q == S_ISSUE);
      o_busy  = (state_q != S_IDLE);
      o_ack   = (state_q == S_ACK) ? grant_q : '0;
   end

   assign o_grant     = grant_q;
   assign o_grant_idx = idx_q;

   always_comb begin
      grant_d  = grant_q;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;
      mask_d   = mask_q;
      case (state_q)
         S_IDLE: begin
            mask_d = '0;
            if (win_found) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               idx_d            = win_idx;
            end
         end
         S_ISSUE: rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
         S_ACK: begin
            mask_d  = grant_q;
            grant_d = '0;
            idx_d   = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         grant_q  <= '0;
         idx_q    <= '0;
         rr_ptr_q <= '0;
         mask_q   <= '0;
      end else begin
         grant_q  <= grant_d;
         idx_q    <= idx_d;
         rr_ptr_q <= rr_ptr_d;
         mask_q   <= mask_d;
      end
   end

`ifdef SS_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          err_q, err_d;

   // A done arriving in the expiry cycle wins, so expiry is qualified by !i_done.
   assign expire  = (state_q == S_WAIT) && (tmo_cnt_q == TW'(TIMEOUT_CYC)) && !i_done;
   assign o_abort = expire;
   assign o_err   = (state_q == S_ACK) && err_q;

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE:  err_d = 1'b0;
         S_ISSUE: begin
            tmo_cnt_d = '0;
            err_d     = 1'b0;
         end
         S_WAIT: begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            err_d     = expire;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end
`else
   assign expire  = 1'b0;
   assign o_abort = 1'b0;
   assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ss_job_arbiter.sv
// tb_ss_job_arbiter: random request batches served by a modelled compute unit,
// checked against a round-robin search model through expected-response queues.
module tb_ss_job_arbiter;
   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int TIMEOUT = 8;

   logic               i_clk = 1'b0;
   logic               i_rst_n;
   logic [NUM_REQ-1:0] i_req;
   logic               i_done;
   logic               o_start;
   logic [NUM_REQ-1:0] o_grant;
   logic [IDX_W-1:0]   o_grant_idx;
   logic [NUM_REQ-1:0] o_ack;
   logic               o_busy;
   logic               o_err;
   logic               o_abort;

   int                 cyc = 0;
   int                 n_checks = 0;
   int                 n_pass = 0;
   int                 m_ptr = 0;
   logic [NUM_REQ-1:0] ack_prev;

   // start: {grant, cycle}; ack: {err, grant, cycle}; abort: {cycle}
   logic [35:0] start_q[$];
   logic [36:0] ack_q[$];
   logic [31:0] abort_q[$];

   ss_job_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_req      (i_req),
      .i_done     (i_done),
      .o_start    (o_start),
      .o_grant    (o_grant),
      .o_grant_idx(o_grant_idx),
      .o_ack      (o_ack),
      .o_busy     (o_busy),
      .o_err      (o_err),
      .o_abort    (o_abort)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "time limit");
   end

   function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input int w);
      onehot = NUM_REQ'(1) << w;
   endfunction

   function automatic int idx_of(input logic [NUM_REQ-1:0] g);
      idx_of = 0;
      for (int i = 0; i < NUM_REQ; i++) if (g[i]) idx_of = i;
   endfunction

   // scoreboard monitor
   always @(negedge i_clk) begin : mon
      logic [35:0] se;
      logic [36:0] ae;
      logic [31:0] be;
      if (i_rst_n) begin
         if (o_start) begin
            if (start_q.size() == 0) check("start_unexpected", 64'(o_start), 0);
            else begin
               se = start_q.pop_front();
               check("start_grant", 64'(o_grant), 64'(se[35:32]));
               check("start_idx", 64'(o_grant_idx), 64'(idx_of(se[35:32])));
               check("start_cycle", 64'(cyc), 64'(se[31:0]));
               check("start_busy", 64'(o_busy), 1);
            end
         end
         if (o_ack != '0) begin
            if (ack_q.size() == 0) check("ack_unexpected", 64'(o_ack), 0);
            else begin
               ae = ack_q.pop_front();
               check("ack_vector", 64'(o_ack), 64'(ae[35:32]));
               check("ack_grant_held", 64'(o_grant), 64'(ae[35:32]));
               check("ack_err", 64'(o_err), 64'(ae[36]));
               check("ack_cycle", 64'(cyc), 64'(ae[31:0]));
            end
         end
         if (o_abort) begin
            if (abort_q.size() == 0) check("abort_unexpected", 64'(o_abort), 0);
            else begin
               be = abort_q.pop_front();
               check("abort_cycle", 64'(cyc), 64'(be));
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      @(negedge i_clk);
      ack_prev = o_ack;
      @(posedge i_clk);
      #1;
   endtask

   task automatic gap(input int n);
      repeat (n) step();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_start"}, 64'(o_start), 0);
      check({tag, "_grant"}, 64'(o_grant), 0);
      check({tag, "_idx"}, 64'(o_grant_idx), 0);
      check({tag, "_ack"}, 64'(o_ack), 0);
      check({tag, "_busy"}, 64'(o_busy), 0);
      check({tag, "_err"}, 64'(o_err), 0);
      check({tag, "_abort"}, 64'(o_abort), 0);
   endtask

   // Raise reqs with the arbiter idle; the unit answers each start after min_d..max_d cycles.
   task automatic run_batch(input logic [NUM_REQ-1:0] reqs, input int min_d, input int max_d);
      int order[$];
      logic [NUM_REQ-1:0] pend;
      int w, job, acks, dly, budget;
      bit unit_busy;
      pend = reqs;
      while (pend != '0) begin
         w = m_ptr;
         while (!pend[w]) w = (w + 1) % NUM_REQ;
         order.push_back(w);
         pend[w] = 1'b0;
         m_ptr = (w + 1) % NUM_REQ;
      end
      i_req = reqs;
      start_q.push_back({onehot(order[0]), 32'(cyc + 1)});
      job = 0; acks = 0; dly = 0; budget = 0; unit_busy = 1'b0;
      while (acks < order.size() && budget < 40 * NUM_REQ) begin
         step();
         budget++;
         if (ack_prev != '0) begin
            acks++;
            i_req = i_req & ~ack_prev;
         end
         if (o_start && !unit_busy) begin
            unit_busy = 1'b1;
            dly = $urandom_range(max_d, min_d);
         end
         if (unit_busy && dly == 0) begin
            i_done = 1'b1;
            unit_busy = 1'b0;
            if (job < order.size()) ack_q.push_back({1'b0, onehot(order[job]), 32'(cyc + 1)});
            if (job + 1 < order.size()) start_q.push_back({onehot(order[job + 1]), 32'(cyc + 3)});
            job++;
         end else begin
            i_done = 1'b0;
            if (unit_busy) dly--;
         end
      end
      i_done = 1'b0;
      i_req = '0;
      check("batch_complete", 64'(acks), 64'(order.size()));
   endtask

   initial begin
      int s, n, hold;
      i_rst_n = 1'b0;
      i_req = 4'b1111;
      i_done = 1'b0;
      ack_prev = '0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_outputs_zero("reset");

      // release with all four pending: order 0,1,2,3, then again 0,1,2,3
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      run_batch(4'b1111, 1, 4);
      gap(2);
      run_batch(4'b1111, 0, 3);

      // single job, done five cycles after start
      gap(2);
      run_batch(4'b0100, 5, 5);

      for (int t = 0; t < 24; t++) begin
         gap($urandom_range(3, 1));
         run_batch(NUM_REQ'($urandom_range(15, 1)), 0, 6);
      end

      // done in the ISSUE cycle, stray done in ACK, owner lags one cycle after its ack
      gap(2);
      i_req = 4'b0010;
      m_ptr = 2;
      start_q.push_back({4'b0010, 32'(cyc + 1)});
      step();
      i_done = 1'b1;
      ack_q.push_back({1'b0, 4'b0010, 32'(cyc + 1)});
      step();
      step();
      i_done = 1'b0;
      step();
      i_req = '0;
      check("mask_no_regrant_start", 64'(o_start), 0);
      check("mask_no_regrant_busy", 64'(o_busy), 0);

      // stray done while idle
      gap(2);
      i_done = 1'b1;
      step();
      i_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stray_done_busy", 64'(o_busy), 0);
      end

`ifdef SS_ARB_TIMEOUT_EN
      // watchdog expiry: abort, then ack with err
      gap(2);
      i_req = 4'b0001;
      m_ptr = 1;
      s = cyc + 1;
      start_q.push_back({4'b0001, 32'(s)});
      abort_q.push_back(32'(s + TIMEOUT + 1));
      ack_q.push_back({1'b1, 4'b0001, 32'(s + TIMEOUT + 2)});
      n = 0;
      while (ack_prev == '0 && n < TIMEOUT + 10) begin
         step();
         n++;
      end
      i_req = '0;
      check("abort_job_acked", 64'(ack_prev), 64'(4'b0001));

      // done in the expiry cycle wins
      gap(2);
      i_req = 4'b0100;
      m_ptr = 3;
      s = cyc + 1;
      start_q.push_back({4'b0100, 32'(s)});
      ack_q.push_back({1'b0, 4'b0100, 32'(s + TIMEOUT + 2)});
      n = 0;
      while (cyc < s + TIMEOUT + 1 && n < TIMEOUT + 10) begin
         step();
         n++;
      end
      i_done = 1'b1;
      step();
      i_done = 1'b0;
      step();
      i_req = '0;
      check("race_job_acked", 64'(ack_prev), 64'(4'b0100));
      hold = 4;
`else
      hold = 20;
`endif

      // job left hanging in WAIT, then reset underneath it
      gap(2);
      i_req = 4'b0100;
      m_ptr = 3;
      start_q.push_back({4'b0100, 32'(cyc + 1)});
      step();
      for (int k = 0; k < hold; k++) begin
         step();
         check("wait_busy", 64'(o_busy), 1);
      end
      @(negedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      i_req = 4'b1010;
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      m_ptr = 0;
      run_batch(4'b1010, 1, 3);

      gap(4);
      check("start_q_drained", 64'(start_q.size()), 0);
      check("ack_q_drained", 64'(ack_q.size()), 0);
      check("abort_q_drained", 64'(abort_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
